led_pio_blink: RTL and testbench



---
 rtl/led_pio_blink.sv | 144 ++++++++++++++
 tb/tb_led_pio_blink.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_blink.sv
// rtl/led_pio_blink.sv - Avalon-MM LED output port with set/clear aliases, blinking and optional PWM dimming
//
// Purpose: WIDTH-bit LED output register on a zero-wait-state Avalon-MM slave.
//   DATA can be written directly or through atomic SET/CLEAR aliases. Bits
//   enabled in BLINK are masked while the blink phase is 0. The phase toggles
//   every PERIOD clock cycles.
// Optional feature: define LED_PIO_PWM_EN to add the DUTY register (address 6)
//   and a free-running 255-step PWM gate on all outputs.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   address    word address (0 DATA, 1 BLINK, 2 SET, 3 CLEAR, 4 PERIOD, 5 STATUS, 6 DUTY)
//   chipselect slave select; write = chipselect & ~write_n
//   write_n    active-low write strobe
//   writedata  write data (upper unused bits ignored)
//   readdata   combinational read data, unused bits 0
//   out_port   registered LED drive
module led_pio_blink #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_W     = 26,
  parameter int DEFAULT_PERIOD = 25000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [PRESCALE_W-1:0] PERIOD_RST = PRESCALE_W'(DEFAULT_PERIOD);

  logic                  wr;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      blink_q, blink_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic                  pwm_gate;

  // Collects writedata bits that no register uses.
  logic unused_wd;
  assign unused_wd = ^writedata;

  assign wr = chipselect & ~write_n;

`ifdef LED_PIO_PWM_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    duty_d = duty_q;
    if (wr && address == 3'd6) duty_d = writedata[7:0];
    // 255-step period: counts 0..254 so DUTY=255 is always on.
    pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
  end

  assign pwm_gate = (pwm_cnt_q < duty_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= 8'd255;
      pwm_cnt_q <= 8'd0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign pwm_gate = 1'b1;
`endif

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr) begin
      case (address)
        3'd0: data_d   = writedata[WIDTH-1:0];
        3'd1: blink_d  = writedata[WIDTH-1:0];
        3'd2: data_d   = data_q | writedata[WIDTH-1:0];
        3'd3: data_d   = data_q & ~writedata[WIDTH-1:0];
        3'd4: period_d = writedata[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    // A PERIOD write restarts the half-period with the LEDs in the "on" phase.
    if (wr && address == 3'd4) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - PRESCALE_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PRESCALE_W'(1);
      phase_d = phase_q;
    end

    // Built from current register values, giving the one-cycle output latency.
    out_d = data_q & ~(blink_q & {WIDTH{~phase_q}}) & {WIDTH{pwm_gate}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      blink_q  <= '0;
      period_q <= PERIOD_RST;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_q    <= '0;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[WIDTH-1:0]      = data_q;
      3'd1: readdata[WIDTH-1:0]      = blink_q;
      3'd4: readdata[PRESCALE_W-1:0] = period_q;
      3'd5: readdata[0]              = phase_q;
`ifdef LED_PIO_PWM_EN
      3'd6: readdata[7:0]            = duty_q;
`endif
      default: ;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_led_pio_blink.sv
// tb/tb_led_pio_blink.sv - self-checking bench for led_pio_blink
module tb_led_pio_blink;

  localparam int W = 8;
  localparam int DEF_P = 25000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int errors = 0;
  int checks = 0;

  led_pio_blink dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #10 clk = ~clk;

  // Bus write sampled on the next rising edge; returns 1ns after that edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Reference blink phase j edges after a PERIOD=p write.
  function automatic logic ref_phase(input int j, input int p);
    if (p == 0) return 1'b1;
    return ((j / p) % 2) == 0;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h expected 0", out_port); end
    bus_read(3'd4, d);
    checks++; if (d !== DEF_P) begin errors++; $display("FAIL reset_period: got %0d expected %0d", d, DEF_P); end
    // Put the block mid-operation, then reset between edges.
    bus_write(3'd0, 32'hFF);
    bus_write(3'd1, 32'h0F);
    bus_write(3'd4, 32'd2);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_async_out: got %0h expected 0", out_port); end
    bus_read(3'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_blink: got %0h expected 0", d); end
    bus_read(3'd4, d);
    checks++; if (d !== DEF_P) begin errors++; $display("FAIL reset_period_mid: got %0d expected %0d", d, DEF_P); end
    bus_read(3'd5, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %0h expected 1", d); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    logic [7:0]  wv [3] = '{8'hA5, 8'h0F, 8'h81};
    logic [2:0]  wa [3] = '{3'd0, 3'd2, 3'd3};
    logic [7:0]  ev [3] = '{8'hA5, 8'hAF, 8'h2E};
    for (int i = 0; i < 3; i++) begin
      logic [7:0] prev;
      prev = out_port;
      bus_write(wa[i], {24'hFFFF00, wv[i]});
      bus_read(3'd0, d);
      checks++; if (d !== {24'h0, ev[i]}) begin errors++; $display("FAIL setclr_read%0d: got %0h expected %0h", i, d, ev[i]); end
      checks++; if (out_port !== prev) begin errors++; $display("FAIL setclr_early%0d: got %0h expected %0h", i, out_port, prev); end
      @(posedge clk); #1;
      checks++; if (out_port !== ev[i]) begin errors++; $display("FAIL setclr_out%0d: got %0h expected %0h", i, out_port, ev[i]); end
    end
    bus_read(3'd2, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL set_reads0: got %0h expected 0", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_reads0: got %0h expected 0", d); end
    bus_write(3'd0, 32'hFFFF_FF5A);
    bus_read(3'd0, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL data_trunc: got %0h expected 5a", d); end
    bus_write(3'd4, 32'hFC00_0005);
    bus_read(3'd4, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL period_trunc: got %0h expected 5", d); end
    bus_write(3'd5, 32'h0);
    bus_read(3'd5, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_ro: got %0h expected 1", d); end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h03);
    bus_write(3'd4, 32'd4);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      e = ref_phase(k - 1, 4) ? 8'h03 : 8'h02;
      checks++; if (out_port !== e) begin errors++; $display("FAIL blink_out k=%0d: got %0h expected %0h", k, out_port, e); end
      bus_read(3'd5, d);
      checks++; if (d[0] !== ref_phase(k, 4)) begin errors++; $display("FAIL blink_phase k=%0d: got %0d expected %0d", k, d[0], ref_phase(k, 4)); end
    end
  endtask

  task automatic test_period_zero();
    logic [31:0] d;
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd4, 32'd0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      bus_read(3'd5, d);
      checks++; if (out_port !== 8'hFF || d[0] !== 1'b1) begin errors++; $display("FAIL period0 k=%0d: got out=%0h phase=%0d expected out=ff phase=1", k, out_port, d[0]); end
    end
  endtask

  task automatic test_period_rewrite();
    logic [31:0] d;
    logic [7:0]  e;
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd4, 32'd20);
    repeat (29) @(posedge clk);
    #1;
    bus_read(3'd5, d);
    checks++; if (d[0] !== 1'b0) begin errors++; $display("FAIL rewrite_pre_phase: got %0d expected 0", d[0]); end
    bus_write(3'd4, 32'd3);
    bus_read(3'd5, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL rewrite_forced: got %0d expected 1", d[0]); end
    checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL rewrite_out0: got %0h expected 0", out_port); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      e = ref_phase(k - 1, 3) ? 8'hFF : 8'h00;
      checks++; if (out_port !== e) begin errors++; $display("FAIL rewrite_out k=%0d: got %0h expected %0h", k, out_port, e); end
      bus_read(3'd5, d);
      checks++; if (d[0] !== ref_phase(k, 3)) begin errors++; $display("FAIL rewrite_phase k=%0d: got %0d expected %0d", k, d[0], ref_phase(k, 3)); end
    end
  endtask

  // Random DATA/SET/CLEAR traffic (plus ignored addresses) during blinking.
  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int          p;
      logic [7:0]  m_data, m_blink, e;
      logic [2:0]  addrs [5] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd7};
      logic [2:0]  a;
      logic [31:0] wd;
      logic        w;
      p = $urandom_range(1, 6);
      m_data  = 8'($urandom);
      m_blink = 8'($urandom);
      bus_write(3'd1, {24'h0, m_blink});
      bus_write(3'd0, {24'h0, m_data});
      bus_write(3'd4, p);
      for (int k = 1; k <= 40; k++) begin
        e = m_data & ~(ref_phase(k - 1, p) ? 8'h00 : m_blink);
        w = ($urandom_range(0, 2) == 0);
        a = addrs[$urandom_range(0, 4)];
        wd = $urandom;
        address = a; writedata = wd; chipselect = w; write_n = ~w;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        checks++; if (out_port !== e) begin errors++; $display("FAIL random r=%0d k=%0d p=%0d: got %0h expected %0h", r, k, p, out_port, e); end
        if (w) begin
          case (a)
            3'd0: m_data = wd[7:0];
            3'd2: m_data = m_data | wd[7:0];
            3'd3: m_data = m_data & ~wd[7:0];
            default: ;
          endcase
        end
      end
    end
  endtask

`ifdef LED_PIO_PWM_EN
  task automatic test_pwm();
    logic [31:0] d;
    int duties [3] = '{64, 0, 255};
    bus_write(3'd1, 32'h0);
    bus_write(3'd0, 32'h01);
    for (int i = 0; i < 3; i++) begin
      int n;
      bus_write(3'd6, duties[i]);
      bus_read(3'd6, d);
      checks++; if (d !== duties[i]) begin errors++; $display("FAIL duty_read%0d: got %0d expected %0d", i, d, duties[i]); end
      repeat (3) @(posedge clk);
      #1;
      n = 0;
      for (int c = 0; c < 255; c++) begin
        @(posedge clk); #1;
        n += int'(out_port[0]);
      end
      checks++; if (n !== duties[i]) begin errors++; $display("FAIL pwm_on_count duty=%0d: got %0d expected %0d", duties[i], n, duties[i]); end
    end
  endtask
`else
  task automatic test_no_pwm();
    logic [31:0] d;
    bus_write(3'd6, 32'hFF);
    bus_read(3'd6, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL addr6_reads0: got %0h expected 0", d); end
    bus_write(3'd7, 32'hFF);
    bus_read(3'd7, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL addr7_reads0: got %0h expected 0", d); end
  endtask
`endif

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    test_reset();
    test_set_clear();
    test_blink();
    test_period_zero();
    test_period_rewrite();
    test_random();
`ifdef LED_PIO_PWM_EN
    test_pwm();
`else
    test_no_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
